// File: rtl/frame_scheduler.sv
// frame_scheduler: gates LED frame output between the pixel FIFO and the
// string drivers. It holds h_blank until a full frame is buffered and the
// minimum frame period has elapsed. It then releases one frame and forces a
// latch gap afterwards. It also keeps frame and underflow statistics.
// Optional ACTIVE watchdog: define FRAME_SCHED_TIMEOUT_EN.
module frame_scheduler #(
  parameter int FIFO_ADDR_WIDTH     = 13,
  parameter int WORDS_PER_FRAME     = 4096,
  parameter int LATCH_CYCLES        = 6000,
  parameter int FRAME_PERIOD_CYCLES = 333333,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
  input  logic                     fifo_underflow,
  input  logic                     string_active,
  input  logic                     clear_err,
  output logic                     h_blank,
  output logic                     frame_start,
  output logic [1:0]               state,
  output logic [15:0]              frame_count,
  output logic [7:0]               underflow_count,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    ACTIVE    = 2'd2,
    LATCH     = 2'd3
  } state_t;

  localparam int LATCH_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [19:0]                PERIOD_MAX  = 20'(FRAME_PERIOD_CYCLES);
  localparam logic [19:0]                PERIOD_GO   = 20'(FRAME_PERIOD_CYCLES - 1);
  localparam logic [LATCH_W-1:0]         LATCH_LAST  = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [FIFO_ADDR_WIDTH:0]   FRAME_WORDS = (FIFO_ADDR_WIDTH + 1)'(WORDS_PER_FRAME);

  state_t               state_reg;
  logic                 h_blank_reg;
  logic                 frame_start_reg;
  logic [15:0]          frame_count_reg;
  logic [7:0]           underflow_count_reg;
  logic                 seen_active;
  logic [LATCH_W-1:0]   latch_cnt;
  logic [19:0]          period_cnt;
  logic                 frame_ready;
  logic                 timeout_hit;

  // Start condition: a whole frame is buffered and the rate limit has expired.
  assign frame_ready = (fifo_full_count >= FRAME_WORDS) && (period_cnt >= PERIOD_GO);

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wd_cnt;
  logic            timeout_err_reg;

  // The watchdog fires on the last idle cycle of ACTIVE that has seen no string activity.
  assign timeout_hit = (state_reg == ACTIVE) && !seen_active && !string_active
                       && (wd_cnt == TO_LAST);

  // The watchdog counter restarts with every frame and only counts before the strings respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_reg == WAIT_DATA) begin
      wd_cnt <= '0;
    end else if (state_reg == ACTIVE && !seen_active && !string_active && !timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_reg <= 1'b1;
    end else if (clear_err) begin
      timeout_err_reg <= 1'b0;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Main sequencer: state, blanking, frame pulse, frame counter and both pacing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      h_blank_reg     <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 16'd0;
      seen_active     <= 1'b0;
      latch_cnt       <= '0;
      period_cnt      <= PERIOD_MAX;
    end else begin
      frame_start_reg <= 1'b0;
      if (period_cnt < PERIOD_MAX) begin
        period_cnt <= period_cnt + 20'd1;
      end
      case (state_reg)
        IDLE: begin
          h_blank_reg <= 1'b1;
          if (enable) begin
            state_reg <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (!enable) begin
            state_reg <= IDLE;
          end else if (frame_ready) begin
            state_reg       <= ACTIVE;
            h_blank_reg     <= 1'b0;
            frame_start_reg <= 1'b1;
            frame_count_reg <= frame_count_reg + 16'd1;
            period_cnt      <= 20'd0;
          end
        end
        ACTIVE: begin
          // Dropping enable here does not abort; the frame always runs to its latch gap.
          if (string_active) begin
            seen_active <= 1'b1;
          end else if (seen_active || timeout_hit) begin
            state_reg   <= LATCH;
            h_blank_reg <= 1'b1;
            seen_active <= 1'b0;
            latch_cnt   <= '0;
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            latch_cnt <= '0;
            state_reg <= enable ? WAIT_DATA : IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          h_blank_reg <= 1'b1;
        end
      endcase
    end
  end

  // Underflow statistics: saturating count; a clear coinciding with an event leaves one.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_count_reg <= 8'd0;
    end else if (clear_err) begin
      underflow_count_reg <= {7'd0, fifo_underflow};
    end else if (fifo_underflow && underflow_count_reg != 8'hFF) begin
      underflow_count_reg <= underflow_count_reg + 8'd1;
    end
  end

  assign h_blank         = h_blank_reg;
  assign frame_start     = frame_start_reg;
  assign state           = state_reg;
  assign frame_count     = frame_count_reg;
  assign underflow_count = underflow_count_reg;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: hand-written frame sequences,
// a table of underflow/clear vectors, and a frame_start scoreboard.
module tb_frame_scheduler;

  localparam int FAW = 13;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [FAW:0]   fifo_full_count;
  logic           fifo_underflow;
  logic           string_active;
  logic           clear_err;
  logic           h_blank;
  logic           frame_start;
  logic [1:0]     state;
  logic [15:0]    frame_count;
  logic [7:0]     underflow_count;
  logic           timeout_err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int f1     = 0;

  typedef struct {
    int cyc;
    int fc;
  } fs_exp_t;
  fs_exp_t sbq[$];

  typedef struct {
    logic uf;
    logic clr;
    int   exp_uc;
    int   exp_to;
  } uvec_t;
  uvec_t uvec[7];

  frame_scheduler #(
    .FIFO_ADDR_WIDTH(FAW),
    .WORDS_PER_FRAME(16),
    .LATCH_CYCLES(10),
    .FRAME_PERIOD_CYCLES(100),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_full_count(fifo_full_count),
    .fifo_underflow(fifo_underflow),
    .string_active(string_active),
    .clear_err(clear_err),
    .h_blank(h_blank),
    .frame_start(frame_start),
    .state(state),
    .frame_count(frame_count),
    .underflow_count(underflow_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every frame_start pulse must match the next expected entry.
  always @(negedge clk) begin
    if (frame_start) begin
      if (sbq.size() == 0) begin
        chk("fs_unexpected", 1, 0);
      end else begin
        fs_exp_t e;
        e = sbq.pop_front();
        chk("fs_cycle", cyc, e.cyc);
        chk("fs_count", int'(frame_count), e.fc);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    uvec[0] = '{uf: 1'b0, clr: 1'b0, exp_uc: 255, exp_to: 0};
    uvec[1] = '{uf: 1'b1, clr: 1'b0, exp_uc: 255, exp_to: 0};
    uvec[2] = '{uf: 1'b1, clr: 1'b1, exp_uc: 1,   exp_to: 0};
    uvec[3] = '{uf: 1'b1, clr: 1'b0, exp_uc: 2,   exp_to: 0};
    uvec[4] = '{uf: 1'b0, clr: 1'b1, exp_uc: 0,   exp_to: 0};
    uvec[5] = '{uf: 1'b0, clr: 1'b0, exp_uc: 0,   exp_to: 0};
    uvec[6] = '{uf: 1'b1, clr: 1'b0, exp_uc: 1,   exp_to: 0};

    reset = 1'b1; enable = 1'b0; fifo_full_count = '0;
    fifo_underflow = 1'b0; string_active = 1'b0; clear_err = 1'b0;
    tick(3);
    chk("rst_state", int'(state), 0);
    chk("rst_h_blank", int'(h_blank), 1);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_underflow", int'(underflow_count), 0);
    chk("rst_timeout", int'(timeout_err), 0);

    // One word short of a frame: stays blanked in WAIT_DATA.
    reset = 1'b0; enable = 1'b1; fifo_full_count = 15;
    tick(50);
    chk("short_state", int'(state), 1);
    chk("short_h_blank", int'(h_blank), 1);
    chk("short_frame_count", int'(frame_count), 0);

    // Full frame buffered: start one cycle later.
    fifo_full_count = 16;
    sbq.push_back('{cyc: cyc + 1, fc: 1});
    f1 = cyc + 1;
    tick(1);
    chk("f1_start", int'(frame_start), 1);
    chk("f1_h_blank", int'(h_blank), 0);
    chk("f1_state", int'(state), 2);
    tick(1);
    chk("f1_pulse_end", int'(frame_start), 0);

    // Strings busy for 30 cycles, then latch gap of exactly 10 cycles.
    string_active = 1'b1;
    tick(30);
    chk("f1_active_hold", int'(state), 2);
    string_active = 1'b0;
    tick(1);
    chk("latch_entry_state", int'(state), 3);
    chk("latch_entry_h_blank", int'(h_blank), 1);
    for (int i = 1; i < 10; i++) begin
      tick(1);
      chk($sformatf("latch_hold%0d", i), int'(state), 3);
    end
    tick(1);
    chk("latch_exit_wait", int'(state), 1);

    // Rate limit: second frame exactly 100 cycles after the first.
    sbq.push_back('{cyc: f1 + 100, fc: 2});
    for (int i = 0; i < 200 && !frame_start; i++) tick(1);
    chk("f2_seen", int'(frame_start), 1);
    chk("f2_frame_count", int'(frame_count), 2);

    // enable dropped mid-frame: frame completes, latch runs, then IDLE.
    string_active = 1'b1; enable = 1'b0;
    tick(5);
    chk("f2_no_abort", int'(state), 2);
    string_active = 1'b0;
    tick(1);
    chk("f2_latch", int'(state), 3);
    tick(9);
    chk("f2_latch_end", int'(state), 3);
    tick(1);
    chk("f2_idle", int'(state), 0);
    tick(150);
    chk("idle_stays", int'(state), 0);
    chk("idle_frame_count", int'(frame_count), 2);

    // Underflow saturation.
    fifo_underflow = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i == 253) chk("uf_254", int'(underflow_count), 254);
    end
    fifo_underflow = 1'b0;
    chk("uf_sat", int'(underflow_count), 255);

    // Table of underflow / clear vectors.
    for (int i = 0; i < 7; i++) begin
      fifo_underflow = uvec[i].uf;
      clear_err = uvec[i].clr;
      tick(1);
      fifo_underflow = 1'b0;
      clear_err = 1'b0;
      chk($sformatf("uvec%0d_count", i), int'(underflow_count), uvec[i].exp_uc);
      chk($sformatf("uvec%0d_to", i), int'(timeout_err), uvec[i].exp_to);
    end

    // Frame with no string activity: watchdog behaviour.
    enable = 1'b1;
    sbq.push_back('{cyc: cyc + 2, fc: 3});
    tick(2);
    chk("f3_start", int'(frame_start), 1);
`ifdef FRAME_SCHED_TIMEOUT_EN
    tick(19);
    chk("to_still_active", int'(state), 2);
    chk("to_not_yet", int'(timeout_err), 0);
    tick(1);
    chk("to_latch", int'(state), 3);
    chk("to_err", int'(timeout_err), 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("to_cleared", int'(timeout_err), 0);
`else
    tick(40);
    chk("noto_active", int'(state), 2);
    chk("noto_err", int'(timeout_err), 0);
`endif

    // Reset mid-frame, then the first frame after reset is not rate-limited.
    reset = 1'b1;
    tick(1);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_h_blank", int'(h_blank), 1);
    chk("mid_rst_frame_count", int'(frame_count), 0);
    chk("mid_rst_underflow", int'(underflow_count), 0);
    reset = 1'b0;
    sbq.push_back('{cyc: cyc + 2, fc: 1});
    tick(2);
    chk("post_rst_start", int'(frame_start), 1);
    tick(2);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
